// File: rtl/fsk_mod.sv
// fsk_mod: FSK modulator driving a phase-accumulator NCO, square-wave output at IF +/- deviation.
// Define FSK_MOD_SHAPE_EN to slew the deviation linearly toward the target instead of hard switching.
module fsk_mod #(
    parameter int PHASE_W  = 16,
    parameter int FCW_IF   = 4096,
    parameter int FCW_DEV  = 512,
    parameter int DEV_STEP = 64,
    parameter int IDLE_TO  = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               start,
    input  logic               data_in,
    input  logic               data_in_valid,
    output logic               signal_out,
    output logic               mod_active,
    output logic [PHASE_W-1:0] fcw_out
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;
    localparam int CNT_W = $clog2(IDLE_TO + 1);
    localparam logic [PHASE_W-1:0] FCW_L = PHASE_W'(FCW_IF);
    localparam logic signed [PHASE_W-1:0] DEV_P = PHASE_W'(FCW_DEV);
    localparam logic signed [PHASE_W-1:0] DEV_N = -DEV_P;
`ifdef FSK_MOD_SHAPE_EN
    localparam logic signed [PHASE_W-1:0] STEP = PHASE_W'(DEV_STEP);
    logic signed [PHASE_W-1:0] diff;
`endif
    logic [0:0]                state, state_nx;
    logic [PHASE_W-1:0]        acc, acc_nx;
    logic signed [PHASE_W-1:0] dev, dev_nx, tgt, tgt_nx, tgt_new, tgt_eff, dev_slew;
    logic [CNT_W-1:0]          to_cnt, to_cnt_nx;
    logic                      sig_nx;

    assign fcw_out    = FCW_L + $unsigned(dev);
    assign mod_active = (state == RUN);

    // A fresh valid retargets immediately so the first deviation step lands on the sampling edge.
    always_comb begin
        tgt_new = data_in ? DEV_P : DEV_N;
        tgt_eff = data_in_valid ? tgt_new : tgt;
`ifdef FSK_MOD_SHAPE_EN
        diff     = tgt_eff - dev;
        dev_slew = (diff > STEP) ? dev + STEP : (diff < -STEP) ? dev - STEP : tgt_eff;
`else
        dev_slew = tgt_eff;
`endif
        state_nx  = state;
        acc_nx    = acc;
        dev_nx    = dev;
        tgt_nx    = tgt;
        to_cnt_nx = to_cnt;
        if (start) begin
            state_nx  = IDLE;
            acc_nx    = '0;
            dev_nx    = '0;
            tgt_nx    = '0;
            to_cnt_nx = '0;
        end else if (state == IDLE) begin
            if (data_in_valid) begin
                state_nx  = RUN;
                tgt_nx    = tgt_new;
                dev_nx    = dev_slew;
                to_cnt_nx = '0;
            end
        end else begin
            acc_nx = acc + fcw_out;
            tgt_nx = tgt_eff;
            dev_nx = dev_slew;
            if (data_in_valid) begin
                to_cnt_nx = '0;
            end else if (to_cnt == CNT_W'(IDLE_TO - 1)) begin
                state_nx  = IDLE;
                acc_nx    = '0;
                dev_nx    = '0;
                tgt_nx    = '0;
                to_cnt_nx = '0;
            end else begin
                to_cnt_nx = to_cnt + 1'b1;
            end
        end
        sig_nx = (state_nx == RUN) ? acc[PHASE_W-1] : 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            acc        <= '0;
            dev        <= '0;
            tgt        <= '0;
            to_cnt     <= '0;
            signal_out <= 1'b0;
        end else if (en) begin
            state      <= state_nx;
            acc        <= acc_nx;
            dev        <= dev_nx;
            tgt        <= tgt_nx;
            to_cnt     <= to_cnt_nx;
            signal_out <= sig_nx;
        end
    end
endmodule

// File: tb/tb_fsk_mod.sv
// tb_fsk_mod: scoreboard bench for fsk_mod in the default hard-FSK build.
module tb_fsk_mod;
    typedef struct {
        logic [15:0] fcw;
        logic        act;
        logic        sig;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        start = 1'b0;
    logic        data_in = 1'b0;
    logic        data_in_valid = 1'b0;
    logic        signal_out;
    logic        mod_active;
    logic [15:0] fcw_out;

    int n_tests = 0;
    int n_fail  = 0;
    exp_t sb[$];

    logic               m_run = 1'b0;
    logic [15:0]        m_acc = '0;
    logic signed [15:0] m_dev = '0;
    logic               m_sig = 1'b0;
    int                 m_cnt = 0;

    fsk_mod dut (
        .clk(clk), .rst(rst), .en(en), .start(start), .data_in(data_in),
        .data_in_valid(data_in_valid), .signal_out(signal_out),
        .mod_active(mod_active), .fcw_out(fcw_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 1'b0;
        m_acc = '0;
        m_dev = '0;
        m_sig = 1'b0;
        m_cnt = 0;
    endtask

    // Expected outputs are computed from the behavioural model and queued before the edge.
    task automatic step(input logic e, input logic s, input logic d, input logic v);
        logic               nrun;
        logic [15:0]        nacc;
        logic signed [15:0] ndev;
        int                 ncnt;
        exp_t               x;
        exp_t               g;
        nrun = m_run; nacc = m_acc; ndev = m_dev; ncnt = m_cnt;
        if (e) begin
            if (s) begin
                nrun = 0; nacc = 0; ndev = 0; ncnt = 0;
            end else if (!m_run) begin
                if (v) begin nrun = 1; ndev = d ? 16'sd512 : -16'sd512; ncnt = 0; end
            end else begin
                nacc = m_acc + 16'(4096 + m_dev);
                if (v) begin
                    ndev = d ? 16'sd512 : -16'sd512; ncnt = 0;
                end else if (m_cnt == 63) begin
                    nrun = 0; nacc = 0; ndev = 0; ncnt = 0;
                end else begin
                    ncnt = m_cnt + 1;
                end
            end
            m_sig = nrun ? m_acc[15] : 1'b0;
            m_run = nrun; m_acc = nacc; m_dev = ndev; m_cnt = ncnt;
        end
        x.fcw = 16'(4096 + m_dev);
        x.act = m_run;
        x.sig = m_sig;
        sb.push_back(x);
        en = e; start = s; data_in = d; data_in_valid = v;
        @(posedge clk);
        #1;
        g = sb.pop_front();
        chk("fcw_out", 32'(fcw_out), 32'(g.fcw));
        chk("mod_active", 32'(mod_active), 32'(g.act));
        chk("signal_out", 32'(signal_out), 32'(g.sig));
    endtask

    initial begin
        int i;
        logic [15:0] f;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_fcw", 32'(fcw_out), 32'd4096);
        chk("rst_act", 32'(mod_active), 32'd0);
        chk("rst_sig", 32'(signal_out), 32'd0);
        rst = 1'b1;
        step(1, 0, 0, 0);
        step(1, 0, 1, 1);
        chk("first_fcw", 32'(fcw_out), 32'd4608);
        chk("first_act", 32'(mod_active), 32'd1);
        repeat (30) step(1, 0, 0, 0);
        for (int b = 0; b < 6; b++) begin
            step(1, 0, b[0], 1);
            chk("alt_fcw", 32'(fcw_out), b[0] ? 32'd4608 : 32'd3584);
            repeat (31) step(1, 0, 0, 0);
        end
        step(1, 0, 1, 1);
        for (i = 1; i <= 100; i++) begin
            step(1, 0, 0, 0);
            if (!mod_active) break;
        end
        chk("timeout_len", 32'(i), 32'd64);
        chk("idle_sig", 32'(signal_out), 32'd0);
        chk("idle_fcw", 32'(fcw_out), 32'd4096);
        step(1, 0, 0, 1);
        repeat (19) step(1, 0, 0, 0);
        f = fcw_out;
        repeat (10) step(0, 1, 1, 1);
        chk("freeze_fcw", 32'(fcw_out), 32'(f));
        for (i = 1; i <= 100; i++) begin
            step(1, 0, 0, 0);
            if (!mod_active) break;
        end
        chk("freeze_timeout", 32'(i + 19), 32'd64);
        step(1, 0, 1, 1);
        repeat (5) step(1, 0, 0, 1);
        repeat (5) step(1, 0, 1, 1);
        step(1, 1, 1, 1);
        chk("start_fcw", 32'(fcw_out), 32'd4096);
        chk("start_sig", 32'(signal_out), 32'd0);
        chk("start_act", 32'(mod_active), 32'd0);
        for (int k = 0; k < 400; k++)
            step(($urandom_range(0, 7) != 0), ($urandom_range(0, 99) == 0),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0));
        step(1, 0, 0, 1);
        repeat (20) step(1, 0, 0, 0);
        rst = 1'b0;
        #2;
        chk("arst_fcw", 32'(fcw_out), 32'd4096);
        chk("arst_act", 32'(mod_active), 32'd0);
        chk("arst_sig", 32'(signal_out), 32'd0);
        model_reset();
        rst = 1'b1;
        step(1, 0, 0, 1);
        chk("rerun_fcw", 32'(fcw_out), 32'd3584);
        repeat (10) step(1, 0, 0, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
